// File: rtl/enemy_unit.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_unit
//  Description : Single enemy actor. It is spawned with a type, spends one
//                cycle loading its type stats, then advances towards the
//                frontmost player unit and attacks with a cooldown. It dies
//                when damage reaches its health, and stays dead for a fixed
//                number of move ticks before it can be spawned again.
//  Ports       : clk         - system clock, all logic on the rising edge
//                reset       - synchronous, active-low reset
//                spawn       - one-cycle spawn request (honoured in IDLE only)
//                spawnType   - requested enemy type (2'b00 = no enemy)
//                moveSCEN    - move / attack / death-count tick
//                damageSCEN  - damage strobe, qualifies damageIn
//                damageIn    - incoming damage amount
//                unitFront   - position of the frontmost player unit
//                position    - current enemy position
//                damageOut   - attack damage, valid with attackValid
//                attackValid - one-cycle attack strobe
//                enemyType   - active type, 2'b00 when no enemy is present
//                alive       - high while the enemy can move and fight
//                deathPulse  - one-cycle strobe on the first cycle dead
//                health      - current health
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_unit #(
    parameter int unsigned      POS_W       = 9,
    parameter int unsigned      HP_W        = 8,
    parameter logic [POS_W-1:0] MAX_POS     = 9'd400,
    parameter int unsigned      COOLDOWN    = 4,
    parameter int unsigned      DEATH_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spawn,
    input  logic [1:0]       spawnType,
    input  logic             moveSCEN,
    input  logic             damageSCEN,
    input  logic [HP_W-1:0]  damageIn,
    input  logic [POS_W-1:0] unitFront,
    output logic [POS_W-1:0] position,
    output logic [HP_W-1:0]  damageOut,
    output logic             attackValid,
    output logic [1:0]       enemyType,
    output logic             alive,
    output logic             deathPulse,
    output logic [HP_W-1:0]  health
);

    // The cooldown counter only ever holds 0..COOLDOWN-1 and the death
    // counter 0..DEATH_TICKS-1, so size them for those ranges.
    localparam int unsigned CD_W = (COOLDOWN > 1)    ? $clog2(COOLDOWN)    : 1;
    localparam int unsigned DT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

    localparam logic [CD_W-1:0] C_CD_RELOAD = CD_W'(COOLDOWN - 1);
    localparam logic [DT_W-1:0] C_DT_LAST   = DT_W'(DEATH_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEPLOY = 2'd1,
        ST_ALIVE  = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    state_t           state_q,        state_d;
    logic [1:0]       type_q,         type_d;
    logic [HP_W-1:0]  health_q,       health_d;
    logic [HP_W-1:0]  power_q,        power_d;
    logic [POS_W-1:0] position_q,     position_d;
    logic [CD_W-1:0]  cooldown_q,     cooldown_d;
    logic [DT_W-1:0]  death_cnt_q,    death_cnt_d;
    logic             attack_valid_q, attack_valid_d;
    logic [HP_W-1:0]  damage_out_q,   damage_out_d;
    logic             death_pulse_q,  death_pulse_d;

    logic             w_lethal;

    // Damage equal to the remaining health is lethal; checking it up front
    // also guarantees the subtraction below can never wrap.
    assign w_lethal = damageSCEN && (damageIn >= health_q);

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        health_d       = health_q;
        power_d        = power_q;
        position_d     = position_q;
        cooldown_d     = cooldown_q;
        death_cnt_d    = death_cnt_q;
        attack_valid_d = 1'b0;
        damage_out_d   = '0;
        death_pulse_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spawn && (spawnType != 2'b00)) begin
                    type_d  = spawnType;
                    state_d = ST_DEPLOY;
                end
            end

            ST_DEPLOY: begin
                case (type_q)
                    2'b01: begin
                        health_d = HP_W'(64);
                        power_d  = HP_W'(16);
                    end
                    2'b10: begin
                        health_d = HP_W'(128);
                        power_d  = HP_W'(32);
                    end
                    default: begin
                        health_d = HP_W'(255);
                        power_d  = HP_W'(64);
                    end
                endcase
                position_d = '0;
                cooldown_d = '0;
                state_d    = ST_ALIVE;
            end

            ST_ALIVE: begin
                if (w_lethal) begin
                    // Dying wins over any move or attack on the same tick.
                    health_d      = '0;
                    death_cnt_d   = '0;
                    death_pulse_d = 1'b1;
                    state_d       = ST_DEAD;
                end else begin
                    if (damageSCEN) begin
                        health_d = health_q - damageIn;
                    end
                    if (moveSCEN) begin
                        if (position_q < unitFront) begin
                            // Cooldown is left untouched while advancing.
                            if (position_q < MAX_POS) begin
                                position_d = position_q + POS_W'(1);
                            end
                        end else if (cooldown_q == '0) begin
                            attack_valid_d = 1'b1;
                            damage_out_d   = power_q;
                            cooldown_d     = C_CD_RELOAD;
                        end else begin
                            cooldown_d = cooldown_q - CD_W'(1);
                        end
                    end
                end
            end

            ST_DEAD: begin
                if (moveSCEN) begin
                    if (death_cnt_q == C_DT_LAST) begin
                        position_d  = '0;
                        death_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        death_cnt_d = death_cnt_q + DT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            type_q         <= 2'b00;
            health_q       <= '0;
            power_q        <= '0;
            position_q     <= '0;
            cooldown_q     <= '0;
            death_cnt_q    <= '0;
            attack_valid_q <= 1'b0;
            damage_out_q   <= '0;
            death_pulse_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            health_q       <= health_d;
            power_q        <= power_d;
            position_q     <= position_d;
            cooldown_q     <= cooldown_d;
            death_cnt_q    <= death_cnt_d;
            attack_valid_q <= attack_valid_d;
            damage_out_q   <= damage_out_d;
            death_pulse_q  <= death_pulse_d;
        end
    end

    assign position    = position_q;
    assign health      = health_q;
    assign damageOut   = damage_out_q;
    assign attackValid = attack_valid_q;
    assign deathPulse  = death_pulse_q;
    assign alive       = (state_q == ST_ALIVE);
    assign enemyType   = ((state_q == ST_DEPLOY) || (state_q == ST_ALIVE)) ? type_q : 2'b00;

endmodule
`default_nettype wire
